// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//
// Grants one of NUM_CH requesters ownership of the shared memory bus and
// drives the owner's address/write controls onto the bus registers. Two
// arbitration modes are available: fixed owner (selected by i_ownerSel) and
// round-robin with a per-owner burst quota. Every ownership change passes
// through an undriven turnaround phase so two masters never drive the pads
// in consecutive cycles. Accepted addresses are decoded into an external
// SRAM enable (below MAP_BASE) or a memory-mapped register enable.
//
// Ports:
//   i_clk           clock
//   i_rstn          synchronous active-low reset
//   i_reqAddr       per-channel address, channel c in [c*ADDR_W +: ADDR_W]
//   i_reqWr         per-channel write flag
//   i_reqEn         per-channel access request
//   i_arbMode       0 = fixed owner, 1 = round-robin
//   i_ownerSel      owner in fixed mode (values >= NUM_CH release the bus)
//   i_disableDrive  external contention guard, forces the pads undriven
//   o_grant         one-hot registered owner, zero when there is no owner
//   o_ack           per-channel pulse, the access was accepted this cycle
//   o_memAddr       registered bus address
//   o_memWr         registered bus write flag
//   o_memExtEn      registered external SRAM enable
//   o_memMapEn      registered memory-mapped register enable
//   o_memDriveEn    tristate enable for the bus pads
module mem_bus_arbiter #(
    parameter int                NUM_CH    = 3,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] MAP_BASE  = 16'hC000,
    parameter int                TURN_CYC  = 1,
    parameter int                MAX_BURST = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [NUM_CH*ADDR_W-1:0]  i_reqAddr,
    input  logic [NUM_CH-1:0]         i_reqWr,
    input  logic [NUM_CH-1:0]         i_reqEn,
    input  logic                      i_arbMode,
    input  logic [$clog2(NUM_CH)-1:0] i_ownerSel,
    input  logic                      i_disableDrive,
    output logic [NUM_CH-1:0]         o_grant,
    output logic [NUM_CH-1:0]         o_ack,
    output logic [ADDR_W-1:0]         o_memAddr,
    output logic                      o_memWr,
    output logic                      o_memExtEn,
    output logic                      o_memMapEn,
    output logic                      o_memDriveEn
);

    localparam int                OWN_W          = $clog2(NUM_CH);
    localparam int                SEL_W          = OWN_W + 1;
    localparam logic [SEL_W-1:0]  CH_LIMIT       = SEL_W'(NUM_CH);
    localparam logic [OWN_W-1:0]  LAST_CH        = OWN_W'(NUM_CH - 1);
    localparam logic [2:0]        TURN_LOAD_IDLE = 3'(TURN_CYC - 1);
    localparam logic [2:0]        TURN_LOAD_EXIT = 3'(TURN_CYC);
    localparam logic [7:0]        BURST_MAX      = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        OWN
    } ArbState;

    ArbState             stateQ, stateD;
    logic [OWN_W-1:0]    ownerQ, ownerD;
    logic [2:0]          cntQ, cntD;
    logic [OWN_W-1:0]    rrPtrQ, rrPtrD;
    logic [7:0]          burstQ, burstD;
    logic [NUM_CH-1:0]   grantQ, grantD;
    logic [ADDR_W-1:0]   memAddrQ, memAddrD;
    logic                memWrQ, memWrD;
    logic                memExtQ, memExtD;
    logic                memMapQ, memMapD;

    logic                ownerValid;
    logic                otherReq;
    logic                quotaBlock;
    logic                accept;
    logic [OWN_W-1:0]    nextAfterOwner;
    logic [OWN_W:0]      idleHit;
    logic [OWN_W:0]      rotHit;

    // Cyclic search for the first set request at or after 'start'.
    // Result MSB flags a hit, the low bits carry the channel index.
    function automatic logic [OWN_W:0] findReq(input logic [NUM_CH-1:0] req,
                                               input int start);
        logic [OWN_W:0] res;
        res = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[(start + k) % NUM_CH]) begin
                res = {1'b1, OWN_W'((start + k) % NUM_CH)};
            end
        end
        return res;
    endfunction

    // Acceptance and arbitration helpers. The quota block stops an owner
    // that has used its round-robin burst from taking one more access while
    // the rotation away from it is being decided.
    always_comb begin
        ownerValid     = ({1'b0, i_ownerSel} < CH_LIMIT);
        otherReq       = |(i_reqEn & ~grantQ);
        quotaBlock     = i_arbMode && (burstQ == BURST_MAX) && otherReq;
        accept         = (|(grantQ & i_reqEn)) && !i_disableDrive && !quotaBlock;
        nextAfterOwner = (ownerQ == LAST_CH) ? '0 : ownerQ + 1'b1;
        idleHit        = findReq(i_reqEn, int'(rrPtrQ));
        rotHit         = findReq(i_reqEn & ~grantQ, int'(nextAfterOwner));
    end

    // Bus register next values: load the owner's access on acceptance,
    // otherwise drop the enables and hold address/write.
    always_comb begin
        memAddrD = memAddrQ;
        memWrD   = memWrQ;
        if (accept) begin
            memAddrD = i_reqAddr[int'(ownerQ)*ADDR_W +: ADDR_W];
            memWrD   = i_reqWr[ownerQ];
        end
        memExtD = accept && (memAddrD < MAP_BASE);
        memMapD = accept && !(memAddrD < MAP_BASE);
    end

    // Ownership FSM next state. Leaving OWN loads one extra turnaround count
    // so the outgoing owner's pads get a full undriven cycle before the
    // normal turnaround gap begins.
    always_comb begin
        stateD = stateQ;
        ownerD = ownerQ;
        cntD   = cntQ;
        rrPtrD = rrPtrQ;
        burstD = burstQ;
        grantD = grantQ;
        unique case (stateQ)
            IDLE: begin
                grantD = '0;
                if (!i_arbMode) begin
                    if (ownerValid) begin
                        stateD = TURN;
                        ownerD = i_ownerSel;
                        cntD   = TURN_LOAD_IDLE;
                    end
                end else if (idleHit[OWN_W]) begin
                    stateD = TURN;
                    ownerD = idleHit[OWN_W-1:0];
                    cntD   = TURN_LOAD_IDLE;
                end
            end
            TURN: begin
                grantD = '0;
                if (cntQ == 3'd0) begin
                    stateD = OWN;
                    grantD = {{(NUM_CH-1){1'b0}}, 1'b1} << ownerQ;
                    burstD = '0;
                end else begin
                    cntD = cntQ - 3'd1;
                end
            end
            OWN: begin
                if (accept && (burstQ != BURST_MAX)) begin
                    burstD = burstQ + 8'd1;
                end
                if (!i_arbMode) begin
                    if (!ownerValid) begin
                        stateD = IDLE;
                        grantD = '0;
                    end else if (i_ownerSel != ownerQ) begin
                        stateD = TURN;
                        ownerD = i_ownerSel;
                        cntD   = TURN_LOAD_EXIT;
                        grantD = '0;
                    end
                end else if (rotHit[OWN_W] && (!i_reqEn[ownerQ] || (burstQ == BURST_MAX))) begin
                    stateD = TURN;
                    ownerD = rotHit[OWN_W-1:0];
                    cntD   = TURN_LOAD_EXIT;
                    rrPtrD = nextAfterOwner;
                    grantD = '0;
                end
            end
            default: begin
                stateD = IDLE;
                grantD = '0;
            end
        endcase
    end

    // State and bus registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            stateQ   <= IDLE;
            ownerQ   <= '0;
            cntQ     <= '0;
            rrPtrQ   <= '0;
            burstQ   <= '0;
            grantQ   <= '0;
            memAddrQ <= '0;
            memWrQ   <= 1'b0;
            memExtQ  <= 1'b0;
            memMapQ  <= 1'b0;
        end else begin
            stateQ   <= stateD;
            ownerQ   <= ownerD;
            cntQ     <= cntD;
            rrPtrQ   <= rrPtrD;
            burstQ   <= burstD;
            grantQ   <= grantD;
            memAddrQ <= memAddrD;
            memWrQ   <= memWrD;
            memExtQ  <= memExtD;
            memMapQ  <= memMapD;
        end
    end

    assign o_grant      = grantQ;
    assign o_ack        = accept ? grantQ : '0;
    assign o_memAddr    = memAddrQ;
    assign o_memWr      = memWrQ;
    assign o_memExtEn   = memExtQ;
    assign o_memMapEn   = memMapQ;
    assign o_memDriveEn = (stateQ == OWN) && !i_disableDrive;

endmodule
